tile_repack: RTL

TILE_REPACK -- requirements
Module: tile_repack

---
 rtl/tile_repack_pkg.sv | 38 +++
 rtl/tile_repack_if.sv | 27 ++
 rtl/tile_addr_gen.sv | 50 +++++
 rtl/tile_repack.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/tile_repack_pkg.sv
// Shared constants, FSM state encoding and the YUV byte packer for tile_repack.
package tile_repack_pkg;

    localparam int WORDS_PER_LINE_DEF = 64;
    localparam int LINES_DEF          = 64;
    localparam int LINE_STRIDE_DEF    = 320;
    localparam int TILE_WORDS         = 4096;

    // Each bank stores three planes back to back; word i of a plane sits at i + offset.
    localparam logic [13:0] PLANE_Y_OFF = 14'd0;
    localparam logic [13:0] PLANE_U_OFF = 14'd4096;
    localparam logic [13:0] PLANE_V_OFF = 14'd8192;

    localparam logic [7:0] LEVEL_SHIFT = 8'd128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_Y = 3'd1,
        RD_U = 3'd2,
        RD_V = 3'd3,
        CAP  = 3'd4,
        WR   = 3'd5,
        DONE = 3'd6
    } state_e;

    // Signed samples to unsigned bytes; U/V high bytes are dropped (4:2:2 output).
    function automatic logic [31:0] pack_yuyv(input logic [15:0] y,
                                              input logic [7:0]  u,
                                              input logic [7:0]  v);
        logic [7:0] y0, y1, uu, vv;
        y0 = y[7:0]  + LEVEL_SHIFT;
        y1 = y[15:8] + LEVEL_SHIFT;
        uu = u       + LEVEL_SHIFT;
        vv = v       + LEVEL_SHIFT;
        return {y0, uu, y1, vv};
    endfunction

endpackage

// File: rtl/tile_repack_if.sv
// Bank read ports and frame-memory write port of tile_repack.
interface tile_repack_if;

    logic [13:0] addrb_o1_r;
    logic [13:0] addrb_o2_r;
    logic        enb_o1_r;
    logic        enb_o2_r;
    logic [15:0] doutb_o1;
    logic [15:0] doutb_o2;
    logic [17:0] addra_all_w;
    logic [31:0] dina_all_w;
    logic        wea_all_w;
    logic        wr_ready;

    modport master (
        output addrb_o1_r, addrb_o2_r, enb_o1_r, enb_o2_r,
        output addra_all_w, dina_all_w, wea_all_w,
        input  doutb_o1, doutb_o2, wr_ready
    );

    modport slave (
        input  addrb_o1_r, addrb_o2_r, enb_o1_r, enb_o2_r,
        input  addra_all_w, dina_all_w, wea_all_w,
        output doutb_o1, doutb_o2, wr_ready
    );

endinterface

// File: rtl/tile_addr_gen.sv
// Frame write address: tile_base + line*LINE_STRIDE + sample, 18-bit wrap, plus last-word flag.
module tile_addr_gen #(
    parameter int WORDS_PER_LINE = 64,
    parameter int LINES          = 64,
    parameter int LINE_STRIDE    = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [17:0] i_base,
    input  logic        i_adv,
    output logic [17:0] o_addr,
    output logic        o_last
);

    localparam int SW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_LAST   = LW'(LINES - 1);
    localparam logic [17:0]   STRIDE      = 18'(LINE_STRIDE);

    logic [SW-1:0] r_sample;
    logic [LW-1:0] r_line;
    logic [17:0]   r_line_base;

    // The line base is accumulated instead of multiplied; the 18-bit adder wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sample    <= '0;
            r_line      <= '0;
            r_line_base <= '0;
        end else if (i_load) begin
            r_sample    <= '0;
            r_line      <= '0;
            r_line_base <= i_base;
        end else if (i_adv) begin
            if (r_sample == SAMPLE_LAST) begin
                r_sample    <= '0;
                r_line      <= r_line + 1'b1;
                r_line_base <= r_line_base + STRIDE;
            end else begin
                r_sample <= r_sample + 1'b1;
            end
        end
    end

    assign o_addr = r_line_base + 18'(r_sample);
    assign o_last = (r_sample == SAMPLE_LAST) && (r_line == LINE_LAST);

endmodule

// File: rtl/tile_repack.sv
// Drains one 4096-word YUV tile from bank o1 or o2 into the packed frame memory.
// Optional TILE_REPACK_BANK_TOGGLE_EN: bank alternates per tile instead of following bank_sel.
module tile_repack
    import tile_repack_pkg::*;
#(
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int LINES          = LINES_DEF,
    parameter int LINE_STRIDE    = LINE_STRIDE_DEF
) (
    input  logic          clk_dwt,
    input  logic          rst,
    input  logic          start,
    input  logic          bank_sel,
    input  logic [17:0]   tile_base,
    tile_repack_if.master mem,
    output logic          busy,
    output logic          done
);

    state_e      r_state;
    state_e      w_next;
    logic [11:0] r_idx;
    logic        r_bank;
    logic [15:0] r_y;
    logic [7:0]  r_u;
    logic [7:0]  r_v;

    logic        w_load;
    logic        w_accept;
    logic        w_last;
    logic        w_bank_req;
    logic        w_rd;
    logic [13:0] w_raddr;
    logic [15:0] w_rdata;
    logic [17:0] w_waddr;
    logic        w_wr;

    assign w_load   = (r_state == IDLE) && start;
    assign w_wr     = (r_state == WR);
    assign w_accept = w_wr && mem.wr_ready;
    assign w_rdata  = r_bank ? mem.doutb_o2 : mem.doutb_o1;

`ifdef TILE_REPACK_BANK_TOGGLE_EN
    logic r_tgl;

    always_ff @(posedge clk_dwt) begin
        if (!rst)
            r_tgl <= 1'b0;
        else if (r_state == DONE)
            r_tgl <= ~r_tgl;
    end

    assign w_bank_req = r_tgl;
`else
    assign w_bank_req = bank_sel;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RD_Y;
            RD_Y:    w_next = RD_U;
            RD_U:    w_next = RD_V;
            RD_V:    w_next = CAP;
            CAP:     w_next = WR;
            WR:      if (mem.wr_ready) w_next = w_last ? DONE : RD_Y;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_dwt) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_bank  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_idx  <= '0;
                r_bank <= w_bank_req;
            end else if (w_accept) begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    // Read data arrives one cycle after its enable, so each plane is captured a state late.
    always_ff @(posedge clk_dwt) begin
        if (!rst) begin
            r_y <= '0;
            r_u <= '0;
            r_v <= '0;
        end else begin
            case (r_state)
                RD_U:    r_y <= w_rdata;
                RD_V:    r_u <= w_rdata[7:0];
                CAP:     r_v <= w_rdata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd    = 1'b1;
        w_raddr = '0;
        case (r_state)
            RD_Y:    w_raddr = {2'b00, r_idx} + PLANE_Y_OFF;
            RD_U:    w_raddr = {2'b00, r_idx} + PLANE_U_OFF;
            RD_V:    w_raddr = {2'b00, r_idx} + PLANE_V_OFF;
            default: w_rd    = 1'b0;
        endcase
    end

    tile_addr_gen #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINES          (LINES),
        .LINE_STRIDE    (LINE_STRIDE)
    ) u_addr_gen (
        .clk    (clk_dwt),
        .rst    (rst),
        .i_load (w_load),
        .i_base (tile_base),
        .i_adv  (w_accept),
        .o_addr (w_waddr),
        .o_last (w_last)
    );

    // Outputs decode from registered state only, so a reset edge clears them all at once.
    assign mem.enb_o1_r    = w_rd && !r_bank;
    assign mem.enb_o2_r    = w_rd &&  r_bank;
    assign mem.addrb_o1_r  = (w_rd && !r_bank) ? w_raddr : '0;
    assign mem.addrb_o2_r  = (w_rd &&  r_bank) ? w_raddr : '0;
    assign mem.wea_all_w   = w_wr;
    assign mem.addra_all_w = w_wr ? w_waddr : '0;
    assign mem.dina_all_w  = w_wr ? pack_yuyv(r_y, r_u, r_v) : '0;

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
